async2sync_multi: RTL and testbench

- N-channel successor of the single-channel async-pulse-to-clock-enable converter.
- Each channel captures asynchronous pulses from foreign logic (e.g. a USB/IFCLK-side strobe) and emits exactly one 1-cycle `strobe` on `clk` per captured pulse.
- Pulses arriving faster than strobes drain are queued in a per-channel saturating pending counter, so none are lost until saturation.
- Sits between interface/async logic and `clk`-domain controllers.

---
 rtl/async2sync_multi_pkg.sv | 33 +++
 rtl/async2sync_multi_if.sv | 20 ++
 rtl/async2sync_multi_ch.sv | 127 ++++++++++++
 rtl/async2sync_multi.sv | 44 ++++
 tb/tb_async2sync_multi.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/async2sync_multi_pkg.sv
// async2sync_pkg: shared defaults and sizing helpers for async2sync_multi.
// Rev 1.0 - initial release.
`default_nettype none

package async2sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_WIDTH_DEF   = 3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pending counter is a plain CNT_WIDTH-bit unsigned value.
  function automatic int pend_width(input int cnt_width);
    return cnt_width;
  endfunction

  function automatic int gap_width(input int min_gap);
    return (clog2(min_gap + 1) < 1) ? 1 : clog2(min_gap + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/async2sync_multi_if.sv
// async2sync_if: per-channel async pulse inputs and clk-domain strobe/status bus.
// Rev 1.0 - initial release.
`default_nettype none

interface async2sync_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] async;
  logic [N_CH-1:0] ovf_clr;
  logic [N_CH-1:0] strobe;
  logic [N_CH-1:0] pending_nz;
  logic [N_CH-1:0] ovf;

  modport master (output async, output ovf_clr,
                  input strobe, input pending_nz, input ovf);
  modport slave  (input async, input ovf_clr,
                  output strobe, output pending_nz, output ovf);
endinterface

`default_nettype wire

// File: rtl/async2sync_multi_ch.sv
// async2sync_ch: one channel - capture, sync, arming, clear handshake, pending queue, ovf.
// Optional MIN_GAP spacing between strobes when ASYNC2SYNC_GAP_EN is defined. Rev 1.0.
`default_nettype none

module async2sync_ch
  import async2sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int MIN_GAP     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  input  logic i_ovf_clr,
  output logic o_strobe,
  output logic o_pending_nz,
  output logic o_ovf
);

  localparam int PEND_W = pend_width(CNT_WIDTH);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic                   r_cap;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_cap_s_d;
  logic                   r_armed;
  logic                   r_clr_req;
  logic [SYNC_STAGES:0]   r_warm;
  logic [PEND_W-1:0]      r_pend;
  logic                   r_strobe;
  logic                   r_pending_nz;
  logic                   r_ovf;

  logic              w_cap_s;
  logic              w_event;
  logic              w_emit;
  logic              w_sat;
  logic              w_gap_zero;
  logic [PEND_W-1:0] w_pend_next;

  // Level-sensitive async set: a pulse of any width leaves r_cap high until handshaken.
  always_ff @(posedge clk or posedge rst or posedge i_async) begin
    if (rst)
      r_cap <= 1'b0;
    else if (i_async)
      r_cap <= 1'b1;
    else if (!r_armed || r_clr_req)
      r_cap <= 1'b0;
  end

  assign w_cap_s = r_sync[SYNC_STAGES-1];
  assign w_event = r_armed && w_cap_s && !r_cap_s_d;

  // r_warm marks when r_sync holds a genuinely sampled input, so arming needs a real low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_cap_s_d <= 1'b0;
      r_armed   <= 1'b0;
      r_clr_req <= 1'b0;
      r_warm    <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], r_cap};
      r_cap_s_d <= w_cap_s;
      r_warm    <= {r_warm[SYNC_STAGES-1:0], 1'b1};
      if (r_warm[SYNC_STAGES] && !w_cap_s)
        r_armed <= 1'b1;
      r_clr_req <= w_event || (r_clr_req && w_cap_s);
    end
  end

`ifdef ASYNC2SYNC_GAP_EN
  localparam int GAP_W = gap_width(MIN_GAP);
  logic [GAP_W-1:0] r_gap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_gap <= '0;
    else if (w_emit)
      r_gap <= GAP_W'(MIN_GAP);
    else if (r_gap != '0)
      r_gap <= r_gap - 1'b1;
  end

  assign w_gap_zero = (r_gap == '0);
`else
  logic [31:0] w_unused_min_gap;
  assign w_unused_min_gap = 32'(MIN_GAP);
  assign w_gap_zero       = 1'b1;
`endif

  assign w_emit = (r_pend != '0) && w_gap_zero;
  assign w_sat  = w_event && !w_emit && (r_pend == PEND_MAX);

  always_comb begin
    w_pend_next = r_pend;
    if (w_event && !w_emit && !w_sat)
      w_pend_next = r_pend + 1'b1;
    else if (w_emit && !w_event)
      w_pend_next = r_pend - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend       <= '0;
      r_strobe     <= 1'b0;
      r_pending_nz <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_pend       <= w_pend_next;
      r_strobe     <= w_emit;
      r_pending_nz <= (w_pend_next != '0);
      if (w_sat)
        r_ovf <= 1'b1;
      else if (i_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign o_strobe     = r_strobe;
  assign o_pending_nz = r_pending_nz;
  assign o_ovf        = r_ovf;

endmodule

`default_nettype wire

// File: rtl/async2sync_multi.sv
// async2sync_multi: N_CH independent async-pulse to clk-enable converters.
// ASYNC2SYNC_GAP_EN enables MIN_GAP strobe spacing per channel. Rev 1.0.
`default_nettype none

module async2sync_multi
  import async2sync_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int MIN_GAP     = 0
) (
  input  logic        clk,
  input  logic        rst,
  async2sync_if.slave bus
);

  logic [N_CH-1:0] w_strobe;
  logic [N_CH-1:0] w_pending_nz;
  logic [N_CH-1:0] w_ovf;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    async2sync_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH),
      .MIN_GAP     (MIN_GAP)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_async      (bus.async[g]),
      .i_ovf_clr    (bus.ovf_clr[g]),
      .o_strobe     (w_strobe[g]),
      .o_pending_nz (w_pending_nz[g]),
      .o_ovf        (w_ovf[g])
    );
  end

  assign bus.strobe     = w_strobe;
  assign bus.pending_nz = w_pending_nz;
  assign bus.ovf        = w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_async2sync_multi.sv
// tb_async2sync_multi: randomized pulses with a timing-arithmetic reference model and scoreboard.
// Rev 1.0.
`default_nettype none

module tb_async2sync_multi;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int CW   = 3;
  localparam int MG   = 10;
  localparam int MAXP = (1 << CW) - 1;
`ifdef ASYNC2SYNC_GAP_EN
  localparam int G = MG;
`else
  localparam int G = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  async2sync_if #(.N_CH(N)) bus ();

  async2sync_multi #(
    .N_CH        (N),
    .SYNC_STAGES (S),
    .CNT_WIDTH   (CW),
    .MIN_GAP     (MG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int vectors = 0;
  int errors  = 0;

  // Reference model: each accepted event has an increment edge and a strobe edge.
  int exp_q   [N][$];
  int acc_inc [N][$];
  int acc_stb [N][$];
  int drop_q  [N][$];
  int last_s  [N];
  bit ovf_exp [N];

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      acc_inc[i].delete();
      acc_stb[i].delete();
      drop_q[i].delete();
      last_s[i]  = -1000;
      ovf_exp[i] = 1'b0;
    end
  endtask

  // Called while cyc = m (between edge m and m+1) when a pulse rises on channel ch.
  task automatic issue(input int ch);
    int e;
    int pend;
    int s;
    bit emit_here;
    e         = cyc + 1 + S;
    pend      = 0;
    emit_here = 1'b0;
    for (int j = 0; j < acc_inc[ch].size(); j++) begin
      if (acc_inc[ch][j] < e && acc_stb[ch][j] >= e) pend++;
      if (acc_stb[ch][j] == e) emit_here = 1'b1;
    end
    if (pend == MAXP && !emit_here) begin
      drop_q[ch].push_back(e);
    end else begin
      s = (e + 1 > last_s[ch] + 1 + G) ? e + 1 : last_s[ch] + 1 + G;
      last_s[ch] = s;
      acc_inc[ch].push_back(e);
      acc_stb[ch].push_back(s);
      exp_q[ch].push_back(s);
    end
  endtask

  task automatic check_ch(input int i, input bit clr);
    int  t;
    bit  exp_nz;
    if (bus.strobe[i]) begin
      vectors++;
      if (exp_q[i].size() == 0) begin
        errors++;
        $display("FAIL strobe[%0d] edge %0d: got strobe, expected none queued", i, cyc);
      end else begin
        t = exp_q[i].pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL strobe[%0d]: got strobe at edge %0d, expected edge %0d", i, cyc, t);
        end
      end
    end else if (exp_q[i].size() != 0 && exp_q[i][0] <= cyc) begin
      vectors++;
      errors++;
      t = exp_q[i].pop_front();
      $display("FAIL strobe[%0d]: got no strobe at edge %0d, expected strobe at edge %0d", i, cyc, t);
    end
    if (drop_q[i].size() != 0 && drop_q[i][0] == cyc) begin
      ovf_exp[i] = 1'b1;
      void'(drop_q[i].pop_front());
    end else if (clr) begin
      ovf_exp[i] = 1'b0;
    end
    while (acc_stb[i].size() != 0 && acc_stb[i][0] <= cyc) begin
      void'(acc_stb[i].pop_front());
      void'(acc_inc[i].pop_front());
    end
    exp_nz = 1'b0;
    for (int j = 0; j < acc_inc[i].size(); j++)
      if (acc_inc[i][j] <= cyc && cyc < acc_stb[i][j]) exp_nz = 1'b1;
    vectors++;
    if (bus.pending_nz[i] !== exp_nz) begin
      errors++;
      $display("FAIL pending_nz[%0d] edge %0d: got %b, expected %b", i, cyc, bus.pending_nz[i], exp_nz);
    end
    vectors++;
    if (bus.ovf[i] !== ovf_exp[i]) begin
      errors++;
      $display("FAIL ovf[%0d] edge %0d: got %b, expected %b", i, cyc, bus.ovf[i], ovf_exp[i]);
    end
  endtask

  initial begin : monitor
    logic [N-1:0] clr_snap;
    forever begin
      @(posedge clk);
      cyc++;
      clr_snap = bus.ovf_clr;
      #1;
      if (!rst)
        for (int i = 0; i < N; i++) check_ch(i, clr_snap[i]);
    end
  end

  int next_ok [N];
  int hi_left [N];

  task automatic check_zero(input string tag);
    vectors++;
    if (bus.strobe !== '0 || bus.pending_nz !== '0 || bus.ovf !== '0) begin
      errors++;
      $display("FAIL %s: got strobe=%b pending_nz=%b ovf=%b, expected all 0",
               tag, bus.strobe, bus.pending_nz, bus.ovf);
    end
  endtask

  task automatic hold_off(input int n);
    for (int i = 0; i < N; i++) next_ok[i] = cyc + n;
  endtask

  // One stimulus cycle; rate r gives a 1-in-(r+1) chance of a pulse when a channel is free.
  task automatic stim_cycle(input int r, input bit all_same);
    logic [N-1:0] glitch;
    int w;
    @(negedge clk);
    glitch = '0;
    for (int i = 0; i < N; i++)
      if (hi_left[i] > 0) begin
        hi_left[i]--;
        if (hi_left[i] == 0) bus.async[i] = 1'b0;
      end
    for (int i = 0; i < N; i++) begin
      if (cyc >= next_ok[i] && (all_same || $urandom_range(0, r) == 0)) begin
        w = all_same ? 2 : $urandom_range(0, 3);
        issue(i);
        next_ok[i] = cyc + 7 + $urandom_range(0, 3);
        if (w == 0) glitch[i] = 1'b1;
        else begin
          bus.async[i] = 1'b1;
          hi_left[i]   = w;
        end
      end
    end
    for (int i = 0; i < N; i++) bus.ovf_clr[i] = ($urandom_range(0, 40) == 0);
    if (glitch != '0) begin
      #2 bus.async = bus.async | glitch;
      #1 bus.async = bus.async & ~glitch;
    end
  endtask

  task automatic settle_inputs();
    repeat (4) stim_cycle(1000000, 1'b0);
  endtask

  initial begin : stimulus
    int busy;
    bus.async   = '0;
    bus.ovf_clr = '0;
    for (int i = 0; i < N; i++) hi_left[i] = 0;
    clear_model();
    bus.async[0] = 1'b1;
    #1 rst = 1'b1;
    #1 check_zero("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold_off(1000000);
    // Level held high across reset release must never be counted.
    repeat (20) @(negedge clk);
    bus.async[0] = 1'b0;
    repeat (8) @(negedge clk);
    issue(0);
    bus.async[0] = 1'b1;
    repeat (3) @(negedge clk);
    bus.async[0] = 1'b0;
    repeat (8) @(negedge clk);
    // Single 1 ns glitch on channel 1, asynchronous to clk.
    issue(1);
    #3 bus.async[1] = 1'b1;
    #1 bus.async[1] = 1'b0;
    repeat (10) @(negedge clk);
    hold_off(cyc);
    stim_cycle(0, 1'b1);
    repeat (12) stim_cycle(1000000, 1'b0);
    // Dense phase: queues build up and, with gap enabled, saturate.
    repeat (1500) stim_cycle(0, 1'b0);
    settle_inputs();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async_reset_midqueue");
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold_off(cyc + 8);
    repeat (10) stim_cycle(1000000, 1'b0);
    hold_off(cyc);
    stim_cycle(0, 1'b1);
    repeat (1200) stim_cycle(3, 1'b0);
    settle_inputs();
    bus.ovf_clr = '0;
    busy = 1;
    for (int k = 0; k < 400 && busy != 0; k++) begin
      @(negedge clk);
      busy = 0;
      for (int i = 0; i < N; i++) busy += exp_q[i].size();
    end
    vectors++;
    if (busy != 0) begin
      errors++;
      $display("FAIL drain: got %0d strobes still outstanding, expected 0", busy);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
